// File: rtl/axis_pkg.sv
// Shared types and constants for the AXI-Stream packet driver: FSM states,
// pattern-mode encodings and the Galois LFSR step used for pseudo-random beats.
package axis_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } state_e;

   localparam logic [31:0] LFSR_POLY = 32'h80200003;

   localparam logic MODE_INC  = 1'b0;
   localparam logic MODE_LFSR = 1'b1;

   // Right-shifting Galois form: when the bit shifted out is 1, the tap mask is applied.
   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
   endfunction

   // An all-zero LFSR state would lock up, so a zero seed becomes 1.
   function automatic logic [31:0] lfsr_seed(input logic [31:0] s);
      return (s == 32'h0) ? 32'h1 : s;
   endfunction

endpackage

// File: rtl/axis_pkt_driver_if.sv
// AXI-Stream master-side bundle (data/valid/last forward, ready back).
interface axis_pkt_driver_if #(
   parameter int width = 8
) ();

   logic [width-1:0] M_TData;
   logic             M_TValid;
   logic             M_TLast;
   logic             M_TReady;

   modport master (output M_TData, output M_TValid, output M_TLast, input M_TReady);
   modport slave  (input M_TData, input M_TValid, input M_TLast, output M_TReady);

endinterface

// File: rtl/axis_lfsr32.sv
// 32-bit Galois LFSR with synchronous load and step enable; load has priority.
module axis_lfsr32
   import axis_pkg::*;
(
   input  logic        CLK,
   input  logic        Reset_n,
   input  logic        load_i,
   input  logic [31:0] seed_i,
   input  logic        step_i,
   output logic [31:0] state_o
);

   logic [31:0] state_q;
   logic [31:0] state_d;

   always_comb begin
      state_d = state_q;
      if (load_i) begin
         state_d = lfsr_seed(seed_i);
      end else if (step_i) begin
         state_d = lfsr_step(state_q);
      end
   end

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= 32'h1;
      end else begin
         state_q <= state_d;
      end
   end

   assign state_o = state_q;

endmodule

// File: rtl/axis_pkt_driver.sv
// AXI-Stream packet generator: emits PktLen beats of incrementing or LFSR data,
// then optionally idles for Gap cycles before accepting the next request.
//
// state | meaning
// IDLE  | waiting for Start; length checked, request latched
// SEND  | M_TValid held high, one beat per handshake, TLast on final beat
// GAP   | forced idle, counting down the latched Gap value
module axis_pkt_driver
   import axis_pkg::*;
#(
   parameter  int width  = 8,
   parameter  int maxLen = 256,
   localparam int LEN_W  = $clog2(maxLen) + 1
) (
   input  logic             CLK,
   input  logic             Reset_n,
   input  logic             Start,
   input  logic [LEN_W-1:0] PktLen,
   input  logic             Mode,
   input  logic [31:0]      Seed,
   input  logic [7:0]       Gap,
   axis_pkt_driver_if.master m_axis,
   output logic             Busy,
   output logic             Done,
   output logic             LenErr,
   output logic [15:0]      PktCount
);

   state_e             state_q, state_d;
   logic [width-1:0]   data_q, data_d;
   logic               valid_q, valid_d;
   logic               last_q, last_d;
   logic [LEN_W-1:0]   remain_q, remain_d;
   logic [7:0]         gap_len_q, gap_len_d;
   logic [7:0]         gap_cnt_q, gap_cnt_d;
   logic               mode_q, mode_d;
   logic               done_q, done_d;
   logic               len_err_q, len_err_d;
   logic [15:0]        pkt_cnt_q, pkt_cnt_d;

   logic               lfsr_load;
   logic               lfsr_step_en;
   logic [31:0]        lfsr_state;
   logic [31:0]        lfsr_nxt;
   logic [31:0]        seed_nz;
   logic               len_ok;
   logic               xfer;

   axis_lfsr32 u_lfsr (
      .CLK     (CLK),
      .Reset_n (Reset_n),
      .load_i  (lfsr_load),
      .seed_i  (Seed),
      .step_i  (lfsr_step_en),
      .state_o (lfsr_state)
   );

   assign len_ok = (PktLen != '0) && (PktLen <= LEN_W'(maxLen));
   assign xfer   = valid_q && m_axis.M_TReady;

   always_comb begin
      state_d      = state_q;
      data_d       = data_q;
      valid_d      = valid_q;
      last_d       = last_q;
      remain_d     = remain_q;
      gap_len_d    = gap_len_q;
      gap_cnt_d    = gap_cnt_q;
      mode_d       = mode_q;
      done_d       = 1'b0;
      len_err_d    = 1'b0;
      pkt_cnt_d    = pkt_cnt_q;
      lfsr_load    = 1'b0;
      lfsr_step_en = 1'b0;
      seed_nz      = lfsr_seed(Seed);
      lfsr_nxt     = lfsr_step(lfsr_state);

      case (state_q)
         ST_IDLE: begin
            if (Start) begin
               if (len_ok) begin
                  state_d   = ST_SEND;
                  valid_d   = 1'b1;
                  last_d    = (PktLen == LEN_W'(1));
                  remain_d  = PktLen - LEN_W'(1);
                  mode_d    = Mode;
                  gap_len_d = Gap;
                  lfsr_load = 1'b1;
                  data_d    = (Mode == MODE_LFSR) ? seed_nz[width-1:0] : Seed[width-1:0];
               end else begin
                  len_err_d = 1'b1;
               end
            end
         end

         ST_SEND: begin
            if (xfer) begin
               lfsr_step_en = (mode_q == MODE_LFSR);
               if (last_q) begin
                  valid_d   = 1'b0;
                  last_d    = 1'b0;
                  done_d    = 1'b1;
                  pkt_cnt_d = pkt_cnt_q + 16'd1;
                  gap_cnt_d = gap_len_q;
                  state_d   = (gap_len_q == 8'd0) ? ST_IDLE : ST_GAP;
               end else begin
                  // Next beat is prepared from the post-step LFSR state so data tracks the register.
                  data_d   = (mode_q == MODE_LFSR) ? lfsr_nxt[width-1:0] : data_q + width'(1);
                  last_d   = (remain_q == LEN_W'(1));
                  remain_d = remain_q - LEN_W'(1);
               end
            end
         end

         ST_GAP: begin
            if (gap_cnt_q <= 8'd1) begin
               state_d = ST_IDLE;
            end
            gap_cnt_d = gap_cnt_q - 8'd1;
         end

         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q   <= ST_IDLE;
         data_q    <= '0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
         remain_q  <= '0;
         gap_len_q <= '0;
         gap_cnt_q <= '0;
         mode_q    <= MODE_INC;
         done_q    <= 1'b0;
         len_err_q <= 1'b0;
         pkt_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         last_q    <= last_d;
         remain_q  <= remain_d;
         gap_len_q <= gap_len_d;
         gap_cnt_q <= gap_cnt_d;
         mode_q    <= mode_d;
         done_q    <= done_d;
         len_err_q <= len_err_d;
         pkt_cnt_q <= pkt_cnt_d;
      end
   end

   assign m_axis.M_TData  = data_q;
   assign m_axis.M_TValid = valid_q;
   assign m_axis.M_TLast  = last_q;
   assign Busy            = (state_q != ST_IDLE);
   assign Done            = done_q;
   assign LenErr          = len_err_q;
   assign PktCount        = pkt_cnt_q;

endmodule

// File: tb/tb_axis_pkt_driver.sv
// Directed bench for axis_pkt_driver: a scoreboard queue of expected beats is filled
// when a packet is requested and drained by a negedge monitor on each handshake.
module tb_axis_pkt_driver;

   localparam int W  = 8;
   localparam int ML = 256;
   localparam int LW = $clog2(ML) + 1;

   typedef struct {
      logic [W-1:0] d;
      logic         l;
   } beat_t;

   logic          CLK = 1'b0;
   logic          Reset_n = 1'b0;
   logic          Start = 1'b0;
   logic [LW-1:0] PktLen = '0;
   logic          Mode = 1'b0;
   logic [31:0]   Seed = '0;
   logic [7:0]    Gap = '0;
   logic          Busy, Done, LenErr;
   logic [15:0]   PktCount;

   int n_tests = 0;
   int n_fail  = 0;
   int n_xfer  = 0;
   int n_last  = 0;
   beat_t sb[$];

   axis_pkt_driver_if #(.width(W)) axis ();

   axis_pkt_driver #(.width(W), .maxLen(ML)) dut (
      .CLK      (CLK),
      .Reset_n  (Reset_n),
      .Start    (Start),
      .PktLen   (PktLen),
      .Mode     (Mode),
      .Seed     (Seed),
      .Gap      (Gap),
      .m_axis   (axis),
      .Busy     (Busy),
      .Done     (Done),
      .LenErr   (LenErr),
      .PktCount (PktCount)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_step(input logic [31:0] s);
      logic [31:0] r;
      r = s >> 1;
      if (s[0]) r = r ^ 32'h80200003;
      return r;
   endfunction

   task automatic push_pkt(input int len, input logic md, input logic [31:0] sd);
      logic [31:0] st;
      beat_t b;
      st = (sd == 32'h0) ? 32'h1 : sd;
      for (int k = 0; k < len; k++) begin
         b.d = md ? st[W-1:0] : W'(sd + 32'(k));
         b.l = (k == len - 1);
         sb.push_back(b);
         st = model_step(st);
      end
   endtask

   task automatic drive_req(input int len, input logic md, input logic [31:0] sd, input logic [7:0] gp);
      Start  = 1'b1;
      PktLen = LW'(len);
      Mode   = md;
      Seed   = sd;
      Gap    = gp;
   endtask

   task automatic send(input int len, input logic md, input logic [31:0] sd, input logic [7:0] gp);
      @(posedge CLK); #1;
      push_pkt(len, md, sd);
      drive_req(len, md, sd, gp);
      @(posedge CLK); #1;
      Start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      logic found;
      found = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge CLK);
         if (Done) begin
            found = 1'b1;
            break;
         end
      end
      chk(tag, 32'(found), 32'd1);
   endtask

   // Handshake monitor: pops expected beats, and checks hold-stable behaviour across stalls.
   logic         pv = 1'b0, pr = 1'b0, pl = 1'b0;
   logic [W-1:0] pd = '0;
   always @(negedge CLK) begin
      beat_t e;
      if (Reset_n) begin
         if (pv && !pr) begin
            chk("stall_valid", 32'(axis.M_TValid), 32'd1);
            chk("stall_data", 32'(axis.M_TData), 32'(pd));
            chk("stall_last", 32'(axis.M_TLast), 32'(pl));
         end
         if (axis.M_TValid && axis.M_TReady) begin
            n_xfer++;
            if (axis.M_TLast) n_last++;
            if (sb.size() == 0) begin
               chk("sb_unexpected_beat", 32'(sb.size()), 32'd1);
            end else begin
               e = sb.pop_front();
               chk("beat_data", 32'(axis.M_TData), 32'(e.d));
               chk("beat_last", 32'(axis.M_TLast), 32'(e.l));
            end
         end
         pv = axis.M_TValid;
         pr = axis.M_TReady;
         pd = axis.M_TData;
         pl = axis.M_TLast;
      end else begin
         pv = 1'b0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [3:0] pat;
      int x0, l0;
      logic found;
      pat = 4'b1001;
      axis.M_TReady = 1'b1;

      // Reset values
      repeat (2) @(negedge CLK);
      chk("rst_valid", 32'(axis.M_TValid), 32'd0);
      chk("rst_last", 32'(axis.M_TLast), 32'd0);
      chk("rst_data", 32'(axis.M_TData), 32'd0);
      chk("rst_busy", 32'(Busy), 32'd0);
      chk("rst_done", 32'(Done), 32'd0);
      chk("rst_lenerr", 32'(LenErr), 32'd0);
      chk("rst_pktcount", 32'(PktCount), 32'd0);

      // First Start sampled on first edge after reset release; 4-beat incrementing packet
      @(posedge CLK); #1;
      Reset_n = 1'b1;
      push_pkt(4, 1'b0, 32'h10);
      drive_req(4, 1'b0, 32'h10, 8'd0);
      @(posedge CLK); #1;
      Start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         chk("inc4_valid", 32'(axis.M_TValid), 32'd1);
         if (i == 0) chk("inc4_busy", 32'(Busy), 32'd1);
      end
      @(negedge CLK);
      chk("inc4_done", 32'(Done), 32'd1);
      chk("inc4_pktcount", 32'(PktCount), 32'd1);
      chk("inc4_valid_low", 32'(axis.M_TValid), 32'd0);
      chk("inc4_busy_low", 32'(Busy), 32'd0);

      // Back-to-back Start in the Done cycle, then stalls; Start stays high but must be ignored
      push_pkt(5, 1'b0, 32'hA0);
      drive_req(5, 1'b0, 32'hA0, 8'd0);
      @(posedge CLK); #1;
      PktLen = LW'(2);
      Seed   = 32'h77;
      x0 = n_xfer;
      l0 = n_last;
      found = 1'b0;
      axis.M_TReady = pat[3];
      for (int c = 0; c < 40; c++) begin
         @(negedge CLK);
         if (c == 0) chk("bubble_valid", 32'(axis.M_TValid), 32'd1);
         if (Done) begin
            found = 1'b1;
            Start = 1'b0;
            break;
         end
         @(posedge CLK); #1;
         axis.M_TReady = pat[3 - ((c + 1) % 4)];
      end
      Start = 1'b0;
      chk("stall_done_seen", 32'(found), 32'd1);
      chk("stall_xfers", 32'(n_xfer - x0), 32'd5);
      chk("stall_lasts", 32'(n_last - l0), 32'd1);
      chk("stall_pktcount", 32'(PktCount), 32'd2);
      axis.M_TReady = 1'b1;
      repeat (2) begin
         @(negedge CLK);
         chk("no_queued_start", 32'(axis.M_TValid), 32'd0);
      end

      // LFSR, seed 0: expected low bytes of states 1, step(1), step(step(1))
      @(posedge CLK); #1;
      sb.push_back('{8'h01, 1'b0});
      sb.push_back('{8'h03, 1'b0});
      sb.push_back('{8'h02, 1'b1});
      drive_req(3, 1'b1, 32'h0, 8'd0);
      @(posedge CLK); #1;
      Start = 1'b0;
      wait_done("lfsr0_done", 20);
      chk("lfsr0_pktcount", 32'(PktCount), 32'd3);

      send(5, 1'b1, 32'h1234ABCD, 8'd0);
      wait_done("lfsr_seed_done", 20);
      chk("lfsr_seed_pktcount", 32'(PktCount), 32'd4);

      // Illegal lengths: 0 and maxLen+1
      @(posedge CLK); #1;
      drive_req(0, 1'b0, 32'h5, 8'd0);
      @(posedge CLK); #1;
      Start = 1'b0;
      @(negedge CLK);
      chk("len0_lenerr", 32'(LenErr), 32'd1);
      chk("len0_valid", 32'(axis.M_TValid), 32'd0);
      @(negedge CLK);
      chk("len0_lenerr_pulse", 32'(LenErr), 32'd0);
      @(posedge CLK); #1;
      drive_req(ML + 1, 1'b0, 32'h5, 8'd0);
      @(posedge CLK); #1;
      Start = 1'b0;
      @(negedge CLK);
      chk("lenmax1_lenerr", 32'(LenErr), 32'd1);
      chk("lenmax1_valid", 32'(axis.M_TValid), 32'd0);
      @(negedge CLK);
      chk("lenmax1_lenerr_pulse", 32'(LenErr), 32'd0);
      chk("lenerr_pktcount", 32'(PktCount), 32'd4);

      // Maximum length packet, incrementing data wrapping through 0xFF
      send(ML, 1'b0, 32'hF0, 8'd0);
      wait_done("maxlen_done", ML + 20);
      chk("maxlen_pktcount", 32'(PktCount), 32'd5);

      // Single-beat packet with Gap=3 and Start held high
      @(posedge CLK); #1;
      push_pkt(1, 1'b0, 32'h55);
      drive_req(1, 1'b0, 32'h55, 8'd3);
      @(posedge CLK);
      @(negedge CLK);
      chk("gap_beat_valid", 32'(axis.M_TValid), 32'd1);
      chk("gap_beat_last", 32'(axis.M_TLast), 32'd1);
      for (int g = 0; g < 3; g++) begin
         @(negedge CLK);
         chk("gap_busy", 32'(Busy), 32'd1);
         chk("gap_valid_low", 32'(axis.M_TValid), 32'd0);
         if (g == 0) chk("gap_done", 32'(Done), 32'd1);
      end
      @(negedge CLK);
      chk("gap_idle_busy", 32'(Busy), 32'd0);
      chk("gap_idle_valid", 32'(axis.M_TValid), 32'd0);
      push_pkt(1, 1'b0, 32'h55);
      @(posedge CLK); #1;
      Start = 1'b0;
      @(negedge CLK);
      chk("gap_restart_valid", 32'(axis.M_TValid), 32'd1);
      found = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge CLK);
         if (!Busy) begin
            found = 1'b1;
            break;
         end
      end
      chk("gap_second_idle", 32'(found), 32'd1);
      chk("gap_pktcount", 32'(PktCount), 32'd7);

      // Reset during beat 2 of 6
      send(6, 1'b0, 32'h30, 8'd0);
      @(negedge CLK);
      @(negedge CLK);
      #2;
      Reset_n = 1'b0;
      #1;
      chk("abort_valid", 32'(axis.M_TValid), 32'd0);
      chk("abort_last", 32'(axis.M_TLast), 32'd0);
      chk("abort_busy", 32'(Busy), 32'd0);
      chk("abort_pktcount", 32'(PktCount), 32'd0);
      sb.delete();
      repeat (3) begin
         @(negedge CLK);
         chk("abort_no_done", 32'(Done), 32'd0);
      end
      @(posedge CLK); #1;
      Reset_n = 1'b1;
      send(2, 1'b0, 32'h40, 8'd0);
      wait_done("post_reset_done", 20);
      chk("post_reset_pktcount", 32'(PktCount), 32'd1);

      repeat (2) @(negedge CLK);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/axis_pkt_driver.md
AXIS_PKT_DRIVER -- requirements
Module: axis_pkt_driver

Interface
REQ-001 Parameter width, default 8: M_TData width in bits; legal range 1..32.
REQ-002 Parameter maxLen, default 256: largest packet length in beats; LEN_W = $clog2(maxLen)+1.
REQ-003 CLK  in  1: the single clock; all state updates on the rising edge.
REQ-004 Reset_n  in  1: reset, asynchronous and active-low.
REQ-005 Start  in  1: packet request; sampled only in IDLE.
REQ-006 PktLen  in  LEN_W: packet length in beats; legal 1..maxLen.
REQ-007 Mode  in  1: data pattern; 0 = incrementing, 1 = LFSR.
REQ-008 Seed  in  32: first-beat value; low width bits are used in incrementing mode.
REQ-009 Gap  in  8: idle cycles forced after a packet's last beat.
REQ-010 M_TData  out  width: beat data.
REQ-011 M_TValid  out  1: beat valid.
REQ-012 M_TLast  out  1: final beat of packet.
REQ-013 M_TReady  in  1: downstream ready.
REQ-014 Busy  out  1: high in SEND and GAP.
REQ-015 Done  out  1: one-cycle pulse at packet completion.
REQ-016 LenErr  out  1: one-cycle pulse when a Start is rejected.
REQ-017 PktCount  out  16: completed packets, modulo 2^16.

Function
REQ-018 The FSM SHALL have three states: IDLE, SEND and GAP.
REQ-019 In IDLE, Start=1 with PktLen in 1..maxLen SHALL latch PktLen, Mode, Seed and Gap, then enter SEND; M_TValid rises on the next cycle (latency 1).
REQ-020 In IDLE, Start=1 with PktLen=0 or PktLen>maxLen SHALL pulse LenErr on the next cycle and remain in IDLE.
REQ-021 Start SHALL be ignored in SEND and GAP, with no queuing.
REQ-022 A beat SHALL transfer only on a cycle with M_TValid=1 and M_TReady=1.
REQ-023 M_TValid, M_TData and M_TLast SHALL be registered, with no combinational path from M_TReady.
REQ-024 While M_TValid=1 and M_TReady=0, M_TData and M_TLast SHALL hold stable, and M_TValid SHALL stay high.
REQ-025 M_TValid SHALL stay high throughout SEND, so beats stream at one per cycle while M_TReady=1.
REQ-026 M_TLast SHALL be high exactly on beat PktLen; for PktLen=1 it is high on the first beat.
REQ-027 In incrementing mode, beat k (k=0..PktLen-1) SHALL equal (Seed+k) mod 2^width.
REQ-028 In LFSR mode, the state SHALL be a 32-bit Galois LFSR with polynomial x^32+x^22+x^2+x+1, initialised to Seed (Seed=0 replaced by 1).
REQ-029 In LFSR mode, the state SHALL advance once per transferred beat, and M_TData SHALL be the state's low width bits.
REQ-030 On the last-beat handshake, if the latched Gap=0 the FSM SHALL enter IDLE; otherwise it SHALL enter GAP.
REQ-031 In GAP, the FSM SHALL count down the latched Gap value, one per cycle, and enter IDLE after exactly Gap cycles.
REQ-032 Done SHALL pulse and PktCount SHALL increment on the cycle after the last-beat handshake.
REQ-033 With Gap=0, a Start presented on the cycle after the last beat SHALL be accepted, giving a one-cycle bubble between packets.
REQ-034 PktCount SHALL wrap from 0xFFFF to 0.

Reset
REQ-035 While Reset_n=0, the FSM SHALL be in IDLE and the following outputs SHALL be 0: M_TValid, M_TLast, M_TData, Busy, Done, LenErr, PktCount.
REQ-036 Reset_n assertion mid-packet SHALL abort the packet immediately, with no TLast and no Done; this is legal and is not flagged.
REQ-037 After Reset_n deasserts, the first Start SHALL be sampled on the first rising edge.

Structure
REQ-038 Package axis_pkg SHALL hold the FSM state enum, the LFSR polynomial constant 32'h80200003 and the Mode encodings.
REQ-039 Sub-module axis_lfsr32 SHALL implement the LFSR: load, step enable and a 32-bit state output.
REQ-040 The remaining logic (FSM, beat counter, gap counter) SHALL live in axis_pkt_driver.

Verification
REQ-041 Stimulus Start, PktLen=4, Mode=0, Seed=0x10, Gap=0, M_TReady=1 -> response data 10,11,12,13 on consecutive cycles, TLast on 13, then Done and PktCount=1.
REQ-042 Stimulus PktLen=5 with M_TReady toggling 1,0,0,1,... -> response data and TLast stable across every stall, exactly 5 transfers and TLast only on the 5th.
REQ-043 Stimulus Mode=1, Seed=0, PktLen=3, width=8 -> response beats equal the low bytes of LFSR states 1, step(1) and step(step(1)).
REQ-044 Stimulus PktLen=0, then PktLen=maxLen+1 -> response one LenErr pulse each, M_TValid stays 0 and PktCount is unchanged.
REQ-045 Stimulus PktLen=1, Gap=3, Start held high -> response a single beat with TLast, Busy high for 3 GAP cycles, and the next packet's M_TValid 1 cycle after IDLE.
REQ-046 Stimulus Reset_n low during beat 2 of 6 -> response M_TValid=0 immediately, no Done, and a subsequent PktLen=2 packet completes normally.
